// File: rtl/fifo_rr_sched.sv
// Two-channel round-robin read scheduler: drains two show-ahead FIFOs onto one output stream.
// Each channel becomes eligible through a hysteresis watermark; grants are bursts of up to blen.
module fifo_rr_sched #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cfg_thd_lo_i,
  input  logic [AW-1:0] cfg_thd_hi_i,
  input  logic [7:0]    cfg_burst_i,
  input  logic [AW-1:0] usedw0_i,
  input  logic [AW-1:0] usedw1_i,
  input  logic          empty0_i,
  input  logic          empty1_i,
  input  logic [DW-1:0] q0_i,
  input  logic [DW-1:0] q1_i,
  output logic          rdreq0_o,
  output logic          rdreq1_o,
  output logic [DW-1:0] dout_o,
  output logic          dout_vld_o,
  output logic          dout_ch_o
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e        state_q;
  logic          gnt_q;
  logic          rr_q;
  logic [8:0]    cnt_q;
  logic [7:0]    blen_q;
  logic [1:0]    rdy_q, rdy_d;
  logic [DW-1:0] dout_q;
  logic          dout_vld_q;
  logic          dout_ch_q;

  logic          empty_gnt;
  logic [DW-1:0] q_gnt;
  logic          pop;
  logic          last;
  logic          gnt_ch;
  logic [7:0]    blen_nxt;

  // Set wins over clear, so inverted thresholds still behave deterministically.
  always_comb begin
    rdy_d = rdy_q;
    if (usedw0_i > cfg_thd_hi_i) begin
      rdy_d[0] = 1'b1;
    end else if (usedw0_i < cfg_thd_lo_i) begin
      rdy_d[0] = 1'b0;
    end
    if (usedw1_i > cfg_thd_hi_i) begin
      rdy_d[1] = 1'b1;
    end else if (usedw1_i < cfg_thd_lo_i) begin
      rdy_d[1] = 1'b0;
    end
  end

  always_comb begin
    empty_gnt = gnt_q ? empty1_i : empty0_i;
    q_gnt     = gnt_q ? q1_i : q0_i;
    pop       = (state_q == StBurst) && !empty_gnt;
    rdreq0_o  = pop && !gnt_q;
    rdreq1_o  = pop && gnt_q;
    last      = (cnt_q == ({1'b0, blen_q} - 9'd1));
    gnt_ch    = (rdy_q == 2'b11) ? rr_q : rdy_q[1];
    blen_nxt  = (cfg_burst_i == 8'd0) ? 8'd1 : cfg_burst_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      blen_q     <= 8'd1;
      rdy_q      <= 2'b00;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_ch_q  <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      dout_vld_q <= pop;
      if (pop) begin
        dout_q    <= q_gnt;
        dout_ch_q <= gnt_q;
      end
      unique case (state_q)
        StIdle: begin
          if (|rdy_q) begin
            gnt_q   <= gnt_ch;
            cnt_q   <= '0;
            blen_q  <= blen_nxt;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          // Burst ends on count or on empty; eligibility dropping does not stop it.
          if (empty_gnt || last) begin
            state_q <= StIdle;
            rr_q    <= ~gnt_q;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = dout_vld_q;
  assign dout_ch_o  = dout_ch_q;

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Directed bench for fifo_rr_sched: queue-based FIFO models feed the DUT, and per-cycle
// rdreq/dout_vld/dout_ch patterns are compared against hand-derived strings.
module tb_fifo_rr_sched;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] thd_lo, thd_hi, usedw0, usedw1;
  logic [7:0]    burst;
  logic          empty0, empty1;
  logic [DW-1:0] q0, q1;
  logic          rdreq0, rdreq1;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_ch;

  always #5 clk = ~clk;

  fifo_rr_sched #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_thd_lo_i(thd_lo),
    .cfg_thd_hi_i(thd_hi),
    .cfg_burst_i (burst),
    .usedw0_i    (usedw0),
    .usedw1_i    (usedw1),
    .empty0_i    (empty0),
    .empty1_i    (empty1),
    .q0_i        (q0),
    .q1_i        (q1),
    .rdreq0_o    (rdreq0),
    .rdreq1_o    (rdreq1),
    .dout_o      (dout),
    .dout_vld_o  (dout_vld),
    .dout_ch_o   (dout_ch)
  );

  logic [DW-1:0] f0[$];
  logic [DW-1:0] f1[$];
  int            wr0 = 0;
  int            wr1 = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] lp_d = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    usedw0 = AW'(f0.size());
    usedw1 = AW'(f1.size());
    empty0 = (f0.size() == 0);
    empty1 = (f1.size() == 0);
    q0     = empty0 ? '0 : f0[0];
    q1     = empty1 ? '0 : f1[0];
  endtask

  // Channel 0 words count up from 0x00, channel 1 words from 0x80.
  task automatic push(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      if (ch == 0) begin
        f0.push_back(8'(wr0 % 128));
        wr0++;
      end else begin
        f1.push_back(8'(128 + wr1 % 128));
        wr1++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, " rst rdreq0"}, 32'(rdreq0), 32'd0);
    check_eq({name, " rst rdreq1"}, 32'(rdreq1), 32'd0);
    check_eq({name, " rst dout_vld"}, 32'(dout_vld), 32'd0);
    check_eq({name, " rst dout"}, 32'(dout), 32'd0);
    check_eq({name, " rst dout_ch"}, 32'(dout_ch), 32'd0);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    f0.delete();
    f1.delete();
    drive_fifo();
    #1;
    check_reset_outputs(name);
    @(posedge clk);
    #1;
  endtask

  // Sample i is taken at the falling edge of the i-th cycle after reset release; pN[i] is the
  // number of words the source writes into FIFO N at the end of cycle i.
  task automatic run_test(input string name, input int n, input int pre0, input int pre1,
                          input int lo, input int hi, input int b,
                          input string er0, input string er1, input string evld,
                          input string ech, input string p0, input string p1);
    logic s0, s1;
    thd_lo = AW'(lo);
    thd_hi = AW'(hi);
    burst  = 8'(b);
    push(0, pre0);
    push(1, pre1);
    drive_fifo();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s rdreq0 c%0d", name, i), 32'(rdreq0), 32'(er0[i] == "1"));
      check_eq($sformatf("%s rdreq1 c%0d", name, i), 32'(rdreq1), 32'(er1[i] == "1"));
      check_eq($sformatf("%s dout_vld c%0d", name, i), 32'(dout_vld), 32'(evld[i] == "1"));
      if (evld[i] == "1") begin
        check_eq($sformatf("%s dout c%0d", name, i), 32'(dout), 32'(lp_d));
        check_eq($sformatf("%s dout_ch c%0d", name, i), 32'(dout_ch), 32'(ech[i] == "1"));
      end
      s0 = rdreq0;
      s1 = rdreq1;
      @(posedge clk);
      #1;
      if (s0 && f0.size() > 0) lp_d = f0.pop_front();
      if (s1 && f1.size() > 0) lp_d = f1.pop_front();
      push(0, int'(p0[i]) - 48);
      push(1, int'(p1[i]) - 48);
      drive_fifo();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    thd_lo = 8'd4;
    thd_hi = 8'd8;
    burst  = 8'd4;
    drive_fifo();

    // Ramp: 9 words land after cycle 0, first rdreq0 in cycle 3, burst of 4, one IDLE gap.
    do_reset("ramp");
    run_test("ramp", 9, 0, 0, 4, 8, 4,
             "000111101", "000000000", "000011110", "----0000-",
             "900000000", "000000000");

    // Both ready from reset: alternating bursts of 3 with one IDLE cycle between grants.
    do_reset("rr");
    run_test("rr", 17, 20, 20, 4, 8, 3,
             "00111000001110000", "00000011100000111", "00011101110111011",
             "---000-111-000-11",
             "00000000000000000", "00000000000000000");

    // Early empty: FIFO 1 runs dry after 5 pops of an 8-word grant; rr then favours channel 0.
    do_reset("empty");
    run_test("empty", 14, 0, 5, 1, 4, 8,
             "00000000000111", "00111110000000", "00011111000011", "---11111----00",
             "00000000500000", "00000000500000");

    // Hysteresis: level 5 keeps eligibility, 3 clears it, 8 is not enough, 9 re-arms.
    do_reset("hyst");
    run_test("hyst", 18, 9, 0, 4, 8, 4,
             "001111011110000001", "000000000000000000", "000111101111000000",
             "---0000-0000------",
             "000000000007001000", "000000000000000000");

    // cfg_burst of zero behaves as single-word bursts.
    do_reset("b0");
    run_test("b0", 9, 12, 0, 4, 8, 0,
             "001010101", "000000000", "000101010", "---0-0-0-",
             "000000000", "000000000");

    // Reset during word 2 of a 6-word burst, then both channels ready after release.
    do_reset("mid");
    run_test("mid", 4, 0, 12, 4, 8, 6,
             "0000", "0011", "0001", "---1", "0000", "0000");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid async");
    run_test("mid2", 10, 10, 0, 4, 8, 6,
             "0011111100", "0000000001", "0001111110", "---000000-",
             "0000000000", "0000000000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
